tx_serializer: RTL and testbench
================================

# tx_serializer

Bit-serial transmit stage directly downstream of the 8b/10b encoder. It accepts one 10-bit encoded symbol per symbol period over a valid/ready handshake and shifts it out one bit per `clk` cycle. It drives electrical idle when no symbol is available, and counts underruns. It sits between the encoder output and the PHY pad/driver model.

## Interface
Parameters:
- `SYM_W`, 10: symbol width in bits; the bit counter wraps at `SYM_W-1`.
- `LSB_FIRST`, 1: 1 transmits `sym_in[0]` first; 0 transmits `sym_in[SYM_W-1]` first.
- `UCNT_W`, 8: width of the underrun counter.

Ports:
- `clk`, in, 1: bit clock. One serial bit per cycle.
- `reset_n`, in, 1: reset, asynchronous, active-low. Clock is `clk`.
- `en`, in, 1: serialisation enable.
- `sym_in`, in, `SYM_W`: encoded symbol, already bit-order-adjusted by the encoder.
- `sym_valid`, in, 1: `sym_in` is valid.
- `sym_ready`, out, 1: combinational. The block accepts `sym_in` this cycle.
- `serial_out`, out, 1: registered serial bit.
- `elec_idle`, out, 1: registered. The line is idle and `serial_out` is 0.
- `underrun`, out, 1: registered one-cycle pulse on an underrun.
- `underrun_cnt`, out, `UCNT_W`: saturating underrun count.

## Operation
- States: `IDLE`, `RUN`.
- `sym_ready = reset_n && en && (state==IDLE || bit_cnt==SYM_W-1)`.
- A transfer occurs when `sym_valid && sym_ready`.
- On a transfer:
  - `shreg <= sym_in`, `bit_cnt <= 0`, `state <= RUN`.
  - `serial_out` takes the first bit as selected by `LSB_FIRST`.
  - `elec_idle <= 0`.
- In `RUN` with `bit_cnt < SYM_W-1`:
  - `bit_cnt` increments.
  - `serial_out` takes the next bit in order.
- At the boundary (`RUN`, `bit_cnt==SYM_W-1`):
  - Transfer: load back-to-back with no gap bit.
  - `en=1`, `sym_valid=0`: go to `IDLE`. `serial_out <= 0`, `elec_idle <= 1`, pulse `underrun`, increment `underrun_cnt`.
  - `en=0`: go to `IDLE`, `serial_out <= 0`, `elec_idle <= 1`. This is not an underrun.
- `en` falling mid-symbol: the current symbol completes. No new load occurs.
- `IDLE`: `serial_out=0`, `elec_idle=1`. Waits for a transfer.
- `underrun_cnt` saturates at `2**UCNT_W-1`. It clears only on reset.
- Symbols are always transmitted whole; a partial symbol is never emitted except on reset.

## Timing
- Reset values:
  - `state=IDLE`, `bit_cnt=0`, `shreg=0`.
  - `serial_out=0`, `elec_idle=1`, `underrun=0`, `underrun_cnt=0`.
  - `sym_ready=0` while `reset_n` is low.
- Latency: a transfer in cycle t puts bit k on `serial_out` in cycle t+1+k, for k = 0..`SYM_W-1`.
- The next `sym_ready` is in cycle t+`SYM_W`. Continuous supply gives an unbroken bit stream.
- `elec_idle` falls in the same cycle bit 0 appears.
- `elec_idle` rises in the cycle after the last bit.
- `underrun` asserts in the cycle after the failed boundary, aligned with `elec_idle` rising.
- Reset asserted mid-symbol: asynchronous clear. The symbol is lost and the line returns to idle immediately.
- Upstream may hold `sym_valid` high indefinitely. Only `sym_ready` paces transfers.

## Configuration
- `TXSER_PRBS7_EN` defined:
  - Adds input `prbs_en`, 1 bit.
  - While `prbs_en=1`:
    - `sym_ready=0`.
    - `serial_out` carries PRBS7 (x^7+x^6+1), one bit per cycle.
    - `elec_idle=0`.
    - The underrun logic is frozen.
  - The LFSR seeds to `7'h7F` on reset and on the rising edge of `prbs_en`.
  - When `prbs_en` falls, the block enters `IDLE`.
- `TXSER_PRBS7_EN` undefined: the port and LFSR are absent, and behaviour is exactly as above.

## Structure
- Shared package `ozphy_tx_pkg`:
  - `txser_state_e` (`IDLE`, `RUN`).
  - `SYM_W` default constant.
  - PRBS7 tap and seed constants.
- Sub-module `prbs7_gen` (ports: `clk`, `reset_n`, `seed_load`, `adv`, `bit_out`). It is instantiated only under `TXSER_PRBS7_EN`.

## Test plan
- Single symbol:
  - Stimulus: reset, `en=1`, one transfer of `10'h17C` (`LSB_FIRST=1`).
  - Required: `serial_out` = 0,0,1,1,1,1,1,0,1,0 over 10 cycles; `elec_idle` low for exactly 10 cycles; then `underrun=1` and `underrun_cnt=1`.
- Back-to-back:
  - Stimulus: `sym_valid` held high with symbols `10'h283` then `10'h17C`.
  - Required: 20 contiguous bits, `sym_ready` high exactly every 10th cycle, no idle gap, no underrun.
- Enable drop:
  - Stimulus: `en` falls at bit 4 of a symbol.
  - Required: remaining 5 bits sent, then idle; `underrun_cnt` unchanged; no further `sym_ready`.
- Reset mid-symbol:
  - Stimulus: assert `reset_n=0` at bit 6.
  - Required: same cycle `serial_out=0`, `elec_idle=1`, `underrun_cnt=0`, `sym_ready=0`.
- Saturation:
  - Stimulus: 300 isolated single symbols with `UCNT_W=8`.
  - Required: `underrun_cnt=255`; `underrun` still pulses each time.
- PRBS (`TXSER_PRBS7_EN` defined):
  - Stimulus: assert `prbs_en`.
  - Required: first 7 bits match the x^7+x^6+1 reference sequence from seed `7'h7F`, the sequence repeats after 127 bits, and `sym_ready=0` throughout.

Source files
------------

// File: rtl/ozphy_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ozphy_tx_pkg
// Description : Shared types and constants for the transmit-side PHY blocks.
//               Provides the serializer state type, the default symbol width,
//               and the PRBS7 (x^7 + x^6 + 1) tap/seed constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ozphy_tx_pkg;

  // Serializer control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } txser_state_e;

  // Default encoded symbol width (one 8b/10b code group)
  localparam int SYM_W_DEFAULT = 10;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;

  // One LFSR step: shift left, feedback bit enters at bit 0
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage : ozphy_tx_pkg
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs7_gen
// Description : PRBS7 (x^7 + x^6 + 1) bit generator. bit_out is the feedback
//               bit of the current state (or of the seed while seed_load is
//               high, so the first bit after a reseed is valid immediately).
// Revision    : 1.0 - initial release
// ============================================================================
module prbs7_gen
  import ozphy_tx_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic seed_load,
  input  logic adv,
  output logic bit_out
);

  logic [6:0] r_lfsr;
  logic [6:0] w_base;

  // Reseeding takes effect in the same cycle so no stale bit escapes
  assign w_base  = seed_load ? PRBS7_SEED : r_lfsr;
  assign bit_out = w_base[PRBS7_TAP_A] ^ w_base[PRBS7_TAP_B];

  // LFSR state: seed on reset, step on reseed or advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= PRBS7_SEED;
    end else if (seed_load || adv) begin
      r_lfsr <= prbs7_step(w_base);
    end
  end

endmodule : prbs7_gen
`default_nettype wire

// File: rtl/tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tx_serializer
// Description : Bit-serial transmit stage after the 8b/10b encoder. Accepts
//               one SYM_W-bit symbol per symbol period over valid/ready and
//               shifts it out one bit per clk. Drives electrical idle when
//               starved and keeps a saturating underrun count.
//               Optional feature macro: TXSER_PRBS7_EN (adds prbs_en input
//               and a PRBS7 test-pattern source).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_serializer
  import ozphy_tx_pkg::*;
#(
  parameter int SYM_W     = SYM_W_DEFAULT,
  parameter int LSB_FIRST = 1,
  parameter int UCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
`ifdef TXSER_PRBS7_EN
  input  logic              prbs_en,
`endif
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              serial_out,
  output logic              elec_idle,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int               CNT_W  = $clog2(SYM_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SYM_W - 1);

  txser_state_e      r_state;
  txser_state_e      w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SYM_W-1:0]  r_shreg;
  logic [SYM_W-1:0]  w_shreg_nxt;
  logic              r_serial;
  logic              w_serial_nxt;
  logic              r_elec_idle;
  logic              w_idle_nxt;
  logic              r_underrun;
  logic              w_underrun_nxt;
  logic [UCNT_W-1:0] r_ucnt;
  logic [UCNT_W-1:0] w_ucnt_nxt;

  logic w_prbs_active;
  logic w_prbs_bit;
  logic w_boundary;
  logic w_ready;
  logic w_xfer;
  logic w_underrun_ev;

`ifdef TXSER_PRBS7_EN
  logic r_prbs_d;
  logic w_seed_load;

  // Remember previous prbs_en to reseed on its rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prbs_d <= 1'b0;
    end else begin
      r_prbs_d <= prbs_en;
    end
  end

  assign w_seed_load   = prbs_en && !r_prbs_d;
  assign w_prbs_active = prbs_en;

  prbs7_gen u_prbs7_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .seed_load (w_seed_load),
    .adv       (prbs_en),
    .bit_out   (w_prbs_bit)
  );
`else
  assign w_prbs_active = 1'b0;
  assign w_prbs_bit    = 1'b0;
`endif

  // Last bit of the current symbol is on the line this cycle
  assign w_boundary = (r_state == RUN) && (r_bit_cnt == C_LAST);

  // Ready gates on reset_n directly so it drops the moment reset asserts
  assign w_ready = reset_n && en && !w_prbs_active &&
                   ((r_state == IDLE) || (r_bit_cnt == C_LAST));
  assign w_xfer  = sym_valid && w_ready;

  // Starved at a boundary while enabled; en low at the boundary is a clean stop
  assign w_underrun_ev = w_boundary && en && !sym_valid && !w_prbs_active;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: PRBS forces IDLE so its falling edge lands there
  always_comb begin
    w_state_nxt = r_state;
    if (w_prbs_active) begin
      w_state_nxt = IDLE;
    end else if (w_xfer) begin
      w_state_nxt = RUN;
    end else if (w_boundary) begin
      w_state_nxt = IDLE;
    end
  end

  // Output/datapath decode: next values for the registered outputs
  always_comb begin
    w_cnt_nxt      = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_serial_nxt   = 1'b0;
    w_idle_nxt     = 1'b1;
    w_underrun_nxt = 1'b0;
    w_ucnt_nxt     = r_ucnt;
    if (w_prbs_active) begin
      w_serial_nxt = w_prbs_bit;
      w_idle_nxt   = 1'b0;
    end else if (w_xfer) begin
      w_shreg_nxt  = sym_in;
      w_cnt_nxt    = '0;
      w_serial_nxt = (LSB_FIRST != 0) ? sym_in[0] : sym_in[SYM_W-1];
      w_idle_nxt   = 1'b0;
    end else if ((r_state == RUN) && !w_boundary) begin
      // Shift so the next bit always sits next to the edge being sent
      w_cnt_nxt    = r_bit_cnt + 1'b1;
      w_shreg_nxt  = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);
      w_serial_nxt = (LSB_FIRST != 0) ? r_shreg[1] : r_shreg[SYM_W-2];
      w_idle_nxt   = 1'b0;
    end else if (w_underrun_ev) begin
      w_underrun_nxt = 1'b1;
      if (r_ucnt != {UCNT_W{1'b1}}) begin
        w_ucnt_nxt = r_ucnt + 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_serial    <= 1'b0;
      r_elec_idle <= 1'b1;
      r_underrun  <= 1'b0;
      r_ucnt      <= '0;
    end else begin
      r_bit_cnt   <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_serial    <= w_serial_nxt;
      r_elec_idle <= w_idle_nxt;
      r_underrun  <= w_underrun_nxt;
      r_ucnt      <= w_ucnt_nxt;
    end
  end

  assign sym_ready    = w_ready;
  assign serial_out   = r_serial;
  assign elec_idle    = r_elec_idle;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ucnt;

endmodule : tx_serializer
`default_nettype wire

// File: tb/tb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_serializer
// Description : Directed self-checking bench for tx_serializer. With
//               TXSER_PRBS7_EN defined it also exercises the PRBS7 source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       serial_out;
  logic       elec_idle;
  logic       underrun;
  logic [7:0] underrun_cnt;
`ifdef TXSER_PRBS7_EN
  logic       prbs_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived line sequences (time order, LSB first)
  int seq_17c[10] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 0};
  int seq_283[10] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  tx_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
`ifdef TXSER_PRBS7_EN
    .prbs_en      (prbs_en),
`endif
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .serial_out   (serial_out),
    .elec_idle    (elec_idle),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    reset_n   = 1'b0;
    en        = 1'b0;
    sym_valid = 1'b0;
    sym_in    = '0;
    repeat (2) cyc();
    chk("rst_serial", serial_out, 0);
    chk("rst_idle", elec_idle, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_cnt", underrun_cnt, 0);
    chk("rst_ready", sym_ready, 0);
    reset_n = 1'b1;
    cyc();

    // Single symbol 10'h17C then starvation
    en = 1'b1; sym_in = 10'h17C; sym_valid = 1'b1;
    #1 chk("t1_ready_idle", sym_ready, 1);
    cyc();
    sym_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_bit%0d", k), serial_out, seq_17c[k]);
      chk($sformatf("t1_idle%0d", k), elec_idle, 0);
      chk($sformatf("t1_ready%0d", k), sym_ready, (k == 9) ? 1 : 0);
      chk($sformatf("t1_urun%0d", k), underrun, 0);
      cyc();
    end
    chk("t1_idle_after", elec_idle, 1);
    chk("t1_serial_after", serial_out, 0);
    chk("t1_underrun", underrun, 1);
    chk("t1_cnt", underrun_cnt, 1);
    cyc();
    chk("t1_underrun_pulse", underrun, 0);

    // Back-to-back 10'h283 then 10'h17C
    sym_in = 10'h283; sym_valid = 1'b1;
    #1 chk("t2_ready0", sym_ready, 1);
    cyc();
    sym_in = 10'h17C;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) sym_valid = 1'b0;
      #1;
      chk($sformatf("t2_bit%0d", k), serial_out, (k < 10) ? seq_283[k] : seq_17c[k-10]);
      chk($sformatf("t2_idle%0d", k), elec_idle, 0);
      chk($sformatf("t2_ready%0d", k), sym_ready, (k == 9 || k == 19) ? 1 : 0);
      chk($sformatf("t2_urun%0d", k), underrun, 0);
      cyc();
    end
    chk("t2_idle_after", elec_idle, 1);
    chk("t2_underrun", underrun, 1);
    chk("t2_cnt", underrun_cnt, 2);
    cyc();

    // Enable drop at bit 4
    sym_in = 10'h283; sym_valid = 1'b1;
    #1 chk("t3_ready0", sym_ready, 1);
    cyc();
    sym_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) en = 1'b0;
      #1;
      chk($sformatf("t3_bit%0d", k), serial_out, seq_283[k]);
      chk($sformatf("t3_idle%0d", k), elec_idle, 0);
      chk($sformatf("t3_ready%0d", k), sym_ready, (k == 9 && k < 4) ? 1 : 0);
      cyc();
    end
    chk("t3_idle_after", elec_idle, 1);
    chk("t3_serial_after", serial_out, 0);
    chk("t3_no_underrun", underrun, 0);
    chk("t3_cnt", underrun_cnt, 2);
    sym_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t3_noready%0d", k), sym_ready, 0);
      chk($sformatf("t3_stays_idle%0d", k), elec_idle, 1);
      cyc();
    end
    sym_valid = 1'b0;

    // Reset at bit 6
    en = 1'b1; sym_in = 10'h17C; sym_valid = 1'b1;
    #1 chk("t4_ready0", sym_ready, 1);
    cyc();
    sym_valid = 1'b0;
    repeat (6) cyc();
    chk("t4_bit6", serial_out, 1);
    reset_n = 1'b0; sym_valid = 1'b1;
    #1;
    chk("t4_serial", serial_out, 0);
    chk("t4_idle", elec_idle, 1);
    chk("t4_cnt", underrun_cnt, 0);
    chk("t4_ready", sym_ready, 0);
    chk("t4_underrun", underrun, 0);
    cyc();
    sym_valid = 1'b0;
    reset_n = 1'b1;
    cyc();

    // Saturation: 300 isolated symbols
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      sym_in = 10'h17C; sym_valid = 1'b1;
      cyc();
      sym_valid = 1'b0;
      repeat (10) cyc();
      if (underrun === 1'b1) pulses++;
      if (i == 253) chk("t5_cnt254", underrun_cnt, 254);
      if (i == 254) chk("t5_cnt255", underrun_cnt, 255);
      cyc();
    end
    chk("t5_pulses", pulses, 300);
    chk("t5_cnt_sat", underrun_cnt, 255);

`ifdef TXSER_PRBS7_EN
    begin
      logic [253:0] bits;
      logic [6:0]   first7;
      int           bad_ctl;
      int           bad_per;
      int           ones;
      bad_ctl = 0; bad_per = 0; ones = 0;
      sym_in = 10'h17C; sym_valid = 1'b1; prbs_en = 1'b1;
      #1 chk("t6_ready_start", sym_ready, 0);
      cyc();
      for (int i = 0; i < 254; i++) begin
        bits[i] = serial_out;
        if (sym_ready !== 1'b0 || elec_idle !== 1'b0) bad_ctl++;
        cyc();
      end
      for (int i = 0; i < 7; i++) first7[6-i] = bits[i];
      for (int i = 0; i < 127; i++) begin
        if (bits[i] != bits[i+127]) bad_per++;
        if (bits[i]) ones++;
      end
      chk("t6_first7", first7, 7'b0000001);
      chk("t6_period", bad_per, 0);
      chk("t6_ones", ones, 64);
      chk("t6_ctl", bad_ctl, 0);
      prbs_en = 1'b0; sym_valid = 1'b0;
      cyc();
      chk("t6_idle_after", elec_idle, 1);
      chk("t6_serial_after", serial_out, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tx_serializer
`default_nettype wire
